// File: rtl/snake_head_stepper_pkg.sv
// Shared heading encoding and game-state type for the snake datapath.
// The keyboard decoder, body logic and renderer all use this encoding.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Opposite headings share the axis bit and differ in the sign bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_head_stepper_move_tick_gen.sv
// Move-period counter: counts 0..STEP_DIV-1 while enabled, flags the last count.
// clr has priority over en; tick is suppressed on a clearing cycle.
module move_tick_gen #(
    parameter int STEP_DIV = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: advances the head one cell per move period, filters
// 180-degree reversals and either wraps or ends the game at the grid edge.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int STEP_DIV = 10000000,
    parameter int WRAP     = 0,
    parameter int XW       = $clog2(GRID_W),
    parameter int YW       = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          enable,
    input  logic [1:0]    direction,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    heading,
    output logic          step_valid,
    output logic          running,
    output logic          collided
);
    localparam logic [XW-1:0] X_CTR = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_CTR = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, nx;
    logic [YW-1:0] y_q, y_d, ny;
    logic [1:0]    heading_q, heading_d, pending_q, pending_d;
    logic          step_valid_q, step_valid_d;
    logic          collided_q, collided_d;
    logic          hit, tick;

    move_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   ((state_q == RUN) && enable),
        .tick (tick)
    );

    // Candidate next cell; explicit compares keep non-power-of-two grids correct.
    always_comb begin
        nx  = x_q;
        ny  = y_q;
        hit = 1'b0;
        case (pending_q)
            DIR_UP: begin
                if (y_q == '0) begin
                    if (WRAP != 0) ny = Y_MAX; else hit = 1'b1;
                end else begin
                    ny = y_q - 1'b1;
                end
            end
            DIR_DOWN: begin
                if (y_q == Y_MAX) begin
                    if (WRAP != 0) ny = '0; else hit = 1'b1;
                end else begin
                    ny = y_q + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (x_q == '0) begin
                    if (WRAP != 0) nx = X_MAX; else hit = 1'b1;
                end else begin
                    nx = x_q - 1'b1;
                end
            end
            default: begin
                if (x_q == X_MAX) begin
                    if (WRAP != 0) nx = '0; else hit = 1'b1;
                end else begin
                    nx = x_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        heading_d    = heading_q;
        pending_d    = pending_q;
        step_valid_d = 1'b0;
        collided_d   = collided_q;
        if (start) begin
            state_d    = RUN;
            x_d        = X_CTR;
            y_d        = Y_CTR;
            heading_d  = DIR_RIGHT;
            pending_d  = DIR_RIGHT;
            collided_d = 1'b0;
        end else if (state_q == RUN) begin
            if (tick) begin
                heading_d = pending_q;
                if (hit) begin
                    collided_d = 1'b1;
                    state_d    = DEAD;
                end else begin
                    x_d          = nx;
                    y_d          = ny;
                    step_valid_d = 1'b1;
                end
                // Filter against the heading that becomes committed at this edge.
                if (!is_reverse(direction, pending_q)) pending_d = direction;
            end else if (!is_reverse(direction, heading_q)) begin
                pending_d = direction;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= X_CTR;
            y_q          <= Y_CTR;
            heading_q    <= DIR_RIGHT;
            pending_q    <= DIR_RIGHT;
            step_valid_q <= 1'b0;
            collided_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            heading_q    <= heading_d;
            pending_q    <= pending_d;
            step_valid_q <= step_valid_d;
            collided_q   <= collided_d;
        end
    end

    assign head_x     = x_q;
    assign head_y     = y_q;
    assign heading    = heading_q;
    assign step_valid = step_valid_q;
    assign running    = (state_q == RUN);
    assign collided   = collided_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench: three instances share stimulus (8x6 edge-hit, 8x6 wrap,
// 5x3 wrap with a 5-cycle period); each task checks the instance it targets.
module tb_snake_head_stepper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] direction = 2'b11;

    logic [2:0] d0_x, d0_y, d1_x, d1_y, d2_x;
    logic [1:0] d2_y, d0_h, d1_h, d2_h;
    logic       d0_sv, d0_run, d0_col, d1_sv, d1_run, d1_col, d2_sv, d2_run, d2_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_head_stepper #(.GRID_W(8), .GRID_H(6), .STEP_DIV(4), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .direction(direction),
        .head_x(d0_x), .head_y(d0_y), .heading(d0_h), .step_valid(d0_sv),
        .running(d0_run), .collided(d0_col));

    snake_head_stepper #(.GRID_W(8), .GRID_H(6), .STEP_DIV(4), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .direction(direction),
        .head_x(d1_x), .head_y(d1_y), .heading(d1_h), .step_valid(d1_sv),
        .running(d1_run), .collided(d1_col));

    snake_head_stepper #(.GRID_W(5), .GRID_H(3), .STEP_DIV(5), .WRAP(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .direction(direction),
        .head_x(d2_x), .head_y(d2_y), .heading(d2_h), .step_valid(d2_sv),
        .running(d2_run), .collided(d2_col));

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (d0_x !== 3'd4) begin errors++; $display("FAIL reset_x: got %0d expected 4", d0_x); end
        checks++; if (d0_y !== 3'd3) begin errors++; $display("FAIL reset_y: got %0d expected 3", d0_y); end
        checks++; if (d0_h !== 2'b11) begin errors++; $display("FAIL reset_heading: got %0d expected 3", d0_h); end
        checks++; if ({d0_sv, d0_run, d0_col} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {d0_sv, d0_run, d0_col}); end
        checks++; if ({d2_x, d2_y} !== {3'd2, 2'd1}) begin errors++; $display("FAIL reset_d2_xy: got %0d,%0d expected 2,1", d2_x, d2_y); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (d1_run !== 1'b0) begin errors++; $display("FAIL idle_no_run: got %0d expected 0", d1_run); end
    endtask

    task automatic test_wall_and_wrap();
        direction = 2'b11;
        enable = 1'b1;
        pulse_start();
        checks++; if ({d0_run, d0_sv} !== 2'b10) begin errors++; $display("FAIL start_run_nosv: got %b expected 10", {d0_run, d0_sv}); end
        for (int k = 1; k <= 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++; if ({d0_sv, d1_sv} !== 2'b00) begin errors++; $display("FAIL gap_sv p%0d c%0d: got %b expected 00", k, c, {d0_sv, d1_sv}); end
            end
            @(negedge clk);
            checks++; if ({d0_sv, d1_sv} !== 2'b11) begin errors++; $display("FAIL step_sv p%0d: got %b expected 11", k, {d0_sv, d1_sv}); end
            checks++; if (d0_x !== 3'(4 + k) || d0_y !== 3'd3) begin errors++; $display("FAIL step_xy p%0d: got %0d,%0d expected %0d,3", k, d0_x, d0_y, 4 + k); end
            checks++; if (d1_x !== 3'(4 + k)) begin errors++; $display("FAIL wrap_step_x p%0d: got %0d expected %0d", k, d1_x, 4 + k); end
        end
        repeat (4) @(negedge clk);
        checks++; if ({d0_sv, d0_col, d0_run} !== 3'b010) begin errors++; $display("FAIL wall_hit sv/col/run: got %b expected 010", {d0_sv, d0_col, d0_run}); end
        checks++; if (d0_x !== 3'd7 || d0_h !== 2'b11) begin errors++; $display("FAIL wall_hold x/h: got %0d/%0d expected 7/3", d0_x, d0_h); end
        checks++; if ({d1_sv, d1_run, d1_col} !== 3'b110) begin errors++; $display("FAIL wrap sv/run/col: got %b expected 110", {d1_sv, d1_run, d1_col}); end
        checks++; if (d1_x !== 3'd0) begin errors++; $display("FAIL wrap_x: got %0d expected 0", d1_x); end
    endtask

    task automatic test_reverse();
        direction = 2'b10;
        repeat (4) @(negedge clk);
        checks++; if ({d1_sv, d1_x, d1_h} !== {1'b1, 3'd1, 2'b11}) begin errors++; $display("FAIL reverse_ignored sv/x/h: got %0d/%0d/%0d expected 1/1/3", d1_sv, d1_x, d1_h); end
        checks++; if ({d0_x, d0_h} !== {3'd7, 2'b11}) begin errors++; $display("FAIL dead_hold x/h: got %0d/%0d expected 7/3", d0_x, d0_h); end
        direction = 2'b00;
        @(negedge clk);
        direction = 2'b10;
        repeat (3) @(negedge clk);
        checks++; if ({d1_sv, d1_x, d1_y, d1_h} !== {1'b1, 3'd1, 3'd2, 2'b00}) begin errors++; $display("FAIL last_accepted sv/x/y/h: got %0d/%0d/%0d/%0d expected 1/1/2/0", d1_sv, d1_x, d1_y, d1_h); end
        direction = 2'b00;
    endtask

    task automatic test_pause();
        repeat (2) @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if ({d1_sv, d1_x, d1_y, d1_h} !== {1'b0, 3'd1, 3'd2, 2'b00}) begin errors++; $display("FAIL pause_hold c%0d sv/x/y/h: got %0d/%0d/%0d/%0d expected 0/1/2/0", c, d1_sv, d1_x, d1_y, d1_h); end
        end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (d1_sv !== 1'b0) begin errors++; $display("FAIL resume_first: got %0d expected 0", d1_sv); end
        @(negedge clk);
        checks++; if ({d1_sv, d1_y} !== {1'b1, 3'd1}) begin errors++; $display("FAIL resume_step sv/y: got %0d/%0d expected 1/1", d1_sv, d1_y); end
    endtask

    task automatic test_restart();
        direction = 2'b11;
        pulse_start();
        checks++; if ({d0_x, d0_y, d0_h} !== {3'd4, 3'd3, 2'b11}) begin errors++; $display("FAIL restart_dead x/y/h: got %0d/%0d/%0d expected 4/3/3", d0_x, d0_y, d0_h); end
        checks++; if ({d0_col, d0_run, d0_sv} !== 3'b010) begin errors++; $display("FAIL restart_dead col/run/sv: got %b expected 010", {d0_col, d0_run, d0_sv}); end
        checks++; if ({d1_x, d1_y, d1_h, d1_run} !== {3'd4, 3'd3, 2'b11, 1'b1}) begin errors++; $display("FAIL restart_run x/y/h/run: got %0d/%0d/%0d/%0d expected 4/3/3/1", d1_x, d1_y, d1_h, d1_run); end
        repeat (3) @(negedge clk);
        checks++; if (d0_sv !== 1'b0) begin errors++; $display("FAIL restart_early_sv: got %0d expected 0", d0_sv); end
        @(negedge clk);
        checks++; if ({d0_sv, d0_x} !== {1'b1, 3'd5}) begin errors++; $display("FAIL restart_first_step sv/x: got %0d/%0d expected 1/5", d0_sv, d0_x); end
    endtask

    task automatic test_start_terminal();
        repeat (3) @(negedge clk);
        pulse_start();
        checks++; if ({d0_sv, d0_x, d0_run} !== {1'b0, 3'd4, 1'b1}) begin errors++; $display("FAIL start_wins sv/x/run: got %0d/%0d/%0d expected 0/4/1", d0_sv, d0_x, d0_run); end
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++; if ({d0_sv, d0_x} !== {1'b1, 3'd5}) begin errors++; $display("FAIL start_wins_next sv/x: got %0d/%0d expected 1/5", d0_sv, d0_x); end
    endtask

    task automatic test_enable_terminal();
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({d0_sv, d0_x} !== {1'b0, 3'd5}) begin errors++; $display("FAIL en_low_terminal sv/x: got %0d/%0d expected 0/5", d0_sv, d0_x); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if ({d0_sv, d0_x} !== {1'b1, 3'd6}) begin errors++; $display("FAIL en_resume_terminal sv/x: got %0d/%0d expected 1/6", d0_sv, d0_x); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({d0_x, d0_y, d0_h} !== {3'd4, 3'd3, 2'b11}) begin errors++; $display("FAIL async_rst x/y/h: got %0d/%0d/%0d expected 4/3/3", d0_x, d0_y, d0_h); end
        checks++; if ({d0_sv, d0_run, d0_col, d1_run} !== 4'b0000) begin errors++; $display("FAIL async_rst flags: got %b expected 0000", {d0_sv, d0_run, d0_col, d1_run}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_period5();
        logic [2:0] exp_x [3];
        exp_x[0] = 3'd3; exp_x[1] = 3'd4; exp_x[2] = 3'd0;
        direction = 2'b11;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            checks++; if (d2_sv !== 1'b0) begin errors++; $display("FAIL p5_gap k%0d: got %0d expected 0", k, d2_sv); end
            @(negedge clk);
            checks++; if ({d2_sv, d2_x, d2_y} !== {1'b1, exp_x[k], 2'd1}) begin errors++; $display("FAIL p5_step k%0d sv/x/y: got %0d/%0d/%0d expected 1/%0d/1", k, d2_sv, d2_x, d2_y, exp_x[k]); end
        end
        direction = 2'b01;
        repeat (5) @(negedge clk);
        checks++; if ({d2_sv, d2_x, d2_y, d2_h} !== {1'b1, 3'd0, 2'd2, 2'b01}) begin errors++; $display("FAIL p5_down sv/x/y/h: got %0d/%0d/%0d/%0d expected 1/0/2/1", d2_sv, d2_x, d2_y, d2_h); end
        repeat (5) @(negedge clk);
        checks++; if ({d2_sv, d2_y, d2_run} !== {1'b1, 2'd0, 1'b1}) begin errors++; $display("FAIL p5_wrap_y sv/y/run: got %0d/%0d/%0d expected 1/0/1", d2_sv, d2_y, d2_run); end
    endtask

    initial begin
        test_reset();
        test_wall_and_wrap();
        test_reverse();
        test_pause();
        test_restart();
        test_start_terminal();
        test_enable_terminal();
        test_async_reset();
        test_period5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
